// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default VGA timing, derived-length helpers and scheduler state encoding.
package vga_timing_pkg;

   localparam int DEF_H_SYNC_FRONT  = 16;
   localparam int DEF_H_SYNC_CYC    = 96;
   localparam int DEF_H_SYNC_BACK   = 48;
   localparam int DEF_H_SYNC_ACT    = 640;
   localparam int DEF_V_SYNC_FRONT  = 10;
   localparam int DEF_V_SYNC_CYC    = 2;
   localparam int DEF_V_SYNC_BACK   = 33;
   localparam int DEF_V_SYNC_ACT    = 480;
   localparam int DEF_V_MARK        = 9;
   localparam int DEF_RD_LEAD       = 1;
   localparam int DEF_PREFILL_WORDS = 256;
   localparam int DEF_FIFO_LW       = 10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREFILL = 2'd1,
      RUN     = 2'd2,
      RESYNC  = 2'd3
   } state_e;

   function automatic int blank_len(input int front, input int cyc, input int back);
      return front + cyc + back;
   endfunction

   function automatic int total_len(input int front, input int cyc, input int back, input int act);
      return blank_len(front, cyc, back) + act;
   endfunction

   localparam int DEF_H_BLANK = blank_len(DEF_H_SYNC_FRONT, DEF_H_SYNC_CYC, DEF_H_SYNC_BACK);
   localparam int DEF_H_TOTAL = total_len(DEF_H_SYNC_FRONT, DEF_H_SYNC_CYC, DEF_H_SYNC_BACK, DEF_H_SYNC_ACT);
   localparam int DEF_V_BLANK = blank_len(DEF_V_SYNC_FRONT, DEF_V_SYNC_CYC, DEF_V_SYNC_BACK);
   localparam int DEF_V_TOTAL = total_len(DEF_V_SYNC_FRONT, DEF_V_SYNC_CYC, DEF_V_SYNC_BACK, DEF_V_SYNC_ACT);

endpackage

// File: rtl/vga_scan_counter.sv
// vga_scan_counter: H/V scan counter pair with enable, synchronous clear and wrap strobes.
module vga_scan_counter
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL = DEF_H_TOTAL,
   parameter int V_TOTAL = DEF_V_TOTAL
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic        clr_i,
   output logic [15:0] h_o,
   output logic [15:0] v_o,
   output logic        h_wrap_o,
   output logic        frame_wrap_o
);

   localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);

   logic [15:0] h_q, h_d, v_q, v_d;
   logic        h_last, v_last;

   assign h_last       = h_q == H_LAST;
   assign v_last       = v_q == V_LAST;
   assign h_wrap_o     = en_i && h_last;
   assign frame_wrap_o = h_wrap_o && v_last;
   assign h_o          = h_q;
   assign v_o          = v_q;

   always_comb begin
      h_d = clr_i ? 16'd0 : en_i ? (h_last ? 16'd0 : h_q + 16'd1) : h_q;
      v_d = clr_i ? 16'd0 : h_wrap_o ? (v_last ? 16'd0 : v_q + 16'd1) : v_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

endmodule

// File: rtl/vga_scan_scheduler.sv
// vga_scan_scheduler: VGA scan timing with FIFO prefill gating, read prefetch and
// underflow-driven resynchronisation at frame boundaries.
module vga_scan_scheduler
   import vga_timing_pkg::*;
#(
   parameter int H_SYNC_FRONT  = DEF_H_SYNC_FRONT,
   parameter int H_SYNC_CYC    = DEF_H_SYNC_CYC,
   parameter int H_SYNC_BACK   = DEF_H_SYNC_BACK,
   parameter int H_SYNC_ACT    = DEF_H_SYNC_ACT,
   parameter int V_SYNC_FRONT  = DEF_V_SYNC_FRONT,
   parameter int V_SYNC_CYC    = DEF_V_SYNC_CYC,
   parameter int V_SYNC_BACK   = DEF_V_SYNC_BACK,
   parameter int V_SYNC_ACT    = DEF_V_SYNC_ACT,
   parameter int V_MARK        = DEF_V_MARK,
   parameter int RD_LEAD       = DEF_RD_LEAD,
   parameter int PREFILL_WORDS = DEF_PREFILL_WORDS,
   parameter int FIFO_LW       = DEF_FIFO_LW
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iEN,
   input  logic [FIFO_LW-1:0] iFIFO_LEVEL,
   input  logic               iFIFO_EMPTY,
   input  logic               iCLR_STATUS,
   output logic [15:0]        oH_Cont,
   output logic [15:0]        oV_Cont,
   output logic               oH_SYNC,
   output logic               oV_SYNC,
   output logic               oBLANK_N,
   output logic               READ_Request,
   output logic               oFIFO_CLR,
   output logic               oFRAME_START,
   output logic               oUNDERFLOW,
   output logic [7:0]         oUFLOW_CNT,
   output logic [15:0]        oFRAME_CNT,
   output logic               oBUSY
);

   localparam int H_BLANK = blank_len(H_SYNC_FRONT, H_SYNC_CYC, H_SYNC_BACK);
   localparam int H_TOTAL = total_len(H_SYNC_FRONT, H_SYNC_CYC, H_SYNC_BACK, H_SYNC_ACT);
   localparam int V_BLANK = blank_len(V_SYNC_FRONT, V_SYNC_CYC, V_SYNC_BACK);
   localparam int V_TOTAL = total_len(V_SYNC_FRONT, V_SYNC_CYC, V_SYNC_BACK, V_SYNC_ACT);

   localparam logic [15:0] HS_LO = 16'(H_SYNC_FRONT);
   localparam logic [15:0] HS_HI = 16'(H_SYNC_FRONT + H_SYNC_CYC);
   localparam logic [15:0] VS_LO = 16'(V_SYNC_FRONT);
   localparam logic [15:0] VS_HI = 16'(V_SYNC_FRONT + V_SYNC_CYC);
   localparam logic [15:0] HB    = 16'(H_BLANK);
   localparam logic [15:0] VB    = 16'(V_BLANK);
   localparam logic [15:0] RD_LO = 16'(H_BLANK - RD_LEAD);
   localparam logic [15:0] RD_HI = 16'(H_TOTAL - RD_LEAD);
   localparam logic [15:0] RD_V  = 16'(V_BLANK + V_MARK);
   localparam logic [FIFO_LW-1:0] PF_LEVEL = FIFO_LW'(PREFILL_WORDS);

   state_e      state_q, state_d;
   logic        pend_q, pend_d;
   logic        uflow_q, uflow_d;
   logic [7:0]  ucnt_q, ucnt_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic [15:0] h, v;
   logic        run, h_wrap, frame_wrap, uflow_ev;

   assign run = state_q == RUN;

   vga_scan_counter #(
      .H_TOTAL(H_TOTAL),
      .V_TOTAL(V_TOTAL)
   ) u_cnt (
      .clk_i       (iCLK),
      .rst_ni      (iRST_N),
      .en_i        (run),
      .clr_i       (!run),
      .h_o         (h),
      .v_o         (v),
      .h_wrap_o    (h_wrap),
      .frame_wrap_o(frame_wrap)
   );

   assign oH_Cont      = h;
   assign oV_Cont      = v;
   assign oH_SYNC      = !(run && h >= HS_LO && h < HS_HI);
   assign oV_SYNC      = !(run && v >= VS_LO && v < VS_HI);
   assign oBLANK_N     = run && h >= HB && v >= VB;
   assign READ_Request = run && h >= RD_LO && h < RD_HI && v >= RD_V;
   assign oFRAME_START = run && h == 16'd0 && v == 16'd0;
   assign oFIFO_CLR    = state_q == RESYNC;
   assign oBUSY        = state_q != IDLE;
   assign oUNDERFLOW   = uflow_q;
   assign oUFLOW_CNT   = ucnt_q;
   assign oFRAME_CNT   = fcnt_q;
   assign uflow_ev     = READ_Request && iFIFO_EMPTY;

   // A frame in progress always completes; disable and resync are only honoured at its end.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = iEN ? PREFILL : IDLE;
         PREFILL: state_d = !iEN ? IDLE : (iFIFO_LEVEL >= PF_LEVEL) ? RUN : PREFILL;
         RUN:     state_d = !frame_wrap ? RUN : !iEN ? IDLE : pend_q ? RESYNC : RUN;
         default: state_d = PREFILL;
      endcase
   end

   always_comb begin
      pend_d  = oFIFO_CLR ? 1'b0 : uflow_ev ? 1'b1 : pend_q;
      uflow_d = uflow_ev ? 1'b1 : iCLR_STATUS ? 1'b0 : uflow_q;
      ucnt_d  = (uflow_ev && ucnt_q != 8'hFF) ? ucnt_q + 8'd1 : ucnt_q;
      fcnt_d  = frame_wrap ? fcnt_q + 16'd1 : fcnt_q;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         uflow_q <= 1'b0;
         ucnt_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         uflow_q <= uflow_d;
         ucnt_q  <= ucnt_d;
         fcnt_q  <= fcnt_d;
      end
   end

endmodule

// File: tb/tb_vga_scan_scheduler.sv
// tb_vga_scan_scheduler: randomized checks of the scan scheduler against a linear-pixel-index
// reference model, using compact timing so many whole frames fit in a short run.
module tb_vga_scan_scheduler;

   localparam int HF = 2, HC = 3, HBK = 4, HA = 8;
   localparam int VF = 1, VC = 1, VBK = 2, VA = 5;
   localparam int MARK = 1, LEAD = 2, PF = 256, LW = 10;
   localparam int HBL = HF + HC + HBK, HT = HBL + HA;
   localparam int VBL = VF + VC + VBK, VT = VBL + VA;
   localparam int FRAME = HT * VT;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          en = 1'b0;
   logic [LW-1:0] lvl = '0;
   logic          emp = 1'b0;
   logic          clr = 1'b0;
   logic [15:0]   h_cont, v_cont, frame_cnt;
   logic          h_sync, v_sync, blank_n, rd_req, fifo_clr, frame_start, uflow, busy;
   logic [7:0]    uflow_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: mode 0 idle, 1 prefill, 2 run, 3 resync; position as a linear pixel index.
   int m_mode, m_p, m_ucnt, m_fcnt;
   bit m_pend, m_uf;

   always #5 clk = ~clk;

   vga_scan_scheduler #(
      .H_SYNC_FRONT(HF), .H_SYNC_CYC(HC), .H_SYNC_BACK(HBK), .H_SYNC_ACT(HA),
      .V_SYNC_FRONT(VF), .V_SYNC_CYC(VC), .V_SYNC_BACK(VBK), .V_SYNC_ACT(VA),
      .V_MARK(MARK), .RD_LEAD(LEAD), .PREFILL_WORDS(PF), .FIFO_LW(LW)
   ) dut (
      .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iFIFO_LEVEL(lvl), .iFIFO_EMPTY(emp),
      .iCLR_STATUS(clr), .oH_Cont(h_cont), .oV_Cont(v_cont), .oH_SYNC(h_sync),
      .oV_SYNC(v_sync), .oBLANK_N(blank_n), .READ_Request(rd_req), .oFIFO_CLR(fifo_clr),
      .oFRAME_START(frame_start), .oUNDERFLOW(uflow), .oUFLOW_CNT(uflow_cnt),
      .oFRAME_CNT(frame_cnt), .oBUSY(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_read();
      int hh = m_p % HT;
      int vv = m_p / HT;
      return m_mode == 2 && hh >= HBL - LEAD && hh < HT - LEAD && vv >= VBL + MARK;
   endfunction

   task automatic m_reset();
      m_mode = 0; m_p = 0; m_ucnt = 0; m_fcnt = 0; m_pend = 0; m_uf = 0;
   endtask

   task automatic check_all();
      int hh = m_p % HT;
      int vv = m_p / HT;
      bit r = m_mode == 2;
      chk("h_cont", 32'(h_cont), 32'(hh));
      chk("v_cont", 32'(v_cont), 32'(vv));
      chk("h_sync", 32'(h_sync), 32'(!(r && hh >= HF && hh < HF + HC)));
      chk("v_sync", 32'(v_sync), 32'(!(r && vv >= VF && vv < VF + VC)));
      chk("blank_n", 32'(blank_n), 32'(r && hh >= HBL && vv >= VBL));
      chk("read_req", 32'(rd_req), 32'(m_read()));
      chk("fifo_clr", 32'(fifo_clr), 32'(m_mode == 3));
      chk("frame_start", 32'(frame_start), 32'(r && m_p == 0));
      chk("underflow", 32'(uflow), 32'(m_uf));
      chk("uflow_cnt", 32'(uflow_cnt), 32'(m_ucnt));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      chk("busy", 32'(busy), 32'(m_mode != 0));
   endtask

   // Advance the model across the coming rising edge using the inputs now applied.
   task automatic m_step();
      if (m_read() && emp) begin
         m_uf = 1;
         m_pend = 1;
         if (m_ucnt < 255) m_ucnt++;
      end else if (clr) m_uf = 0;
      case (m_mode)
         0: if (en) m_mode = 1;
         1: m_mode = !en ? 0 : (int'(lvl) >= PF) ? 2 : 1;
         2: if (m_p == FRAME - 1) begin
               m_p = 0;
               m_fcnt = (m_fcnt + 1) % 65536;
               m_mode = !en ? 0 : m_pend ? 3 : 2;
            end else m_p++;
         default: begin m_pend = 0; m_mode = 1; end
      endcase
   endtask

   task automatic cyc(input bit e, input int l, input bit em, input bit c);
      @(negedge clk);
      check_all();
      en = e; lvl = LW'(l); emp = em; clr = c;
      m_step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      m_step();
   endtask

   initial begin
      #1;
      do_reset();
      for (int i = 0; i < 340; i++) cyc(1, 300, 0, 0);
      // Disable mid-frame: frame must run to completion, then idle.
      for (int i = 0; i < 200; i++) cyc(0, 300, 0, 0);
      for (int i = 0; i < 40; i++) cyc(1, 255, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 256, 0, 0);
      for (int i = 0; i < 1200; i++) cyc(1, 300, $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
      // Continuous underflow drives the event counter into saturation.
      for (int i = 0; i < 2400; i++) cyc(1, 300, 1, $urandom_range(0, 3) == 0);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 149) != 0, $urandom_range(240, 272),
             $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
      for (int i = 0; i < 200; i++) cyc(1, 300, 0, 0);
      @(negedge clk);
      check_all();
      #2 do_reset();
      for (int i = 0; i < 400; i++) cyc(1, 300, $urandom_range(0, 49) == 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
